// File: rtl/mul_dispatch_ctrl.sv
// mul_dispatch_ctrl: request/response sequencer around a start/done multiplier with zero bypass and timeout
module mul_dispatch_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 32,
  parameter int DONE_MASK = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic [WIDTH-1:0]   mul_multiplier,
  input  logic [2*WIDTH-1:0] mul_outbus,
  input  logic               mul_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_timeout,
  output logic               busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic done_q, tmo, zero, acc;
  assign req_ready = state == IDLE;
  assign mul_start = state == START;
  assign rsp_valid = state == HOLD;
  assign busy      = state != IDLE;
  // next state; a qualified done beats a simultaneous timeout
  always_comb begin
    acc     = state == IDLE && req_valid;
    zero    = req_a == '0 || req_b == '0;
    done_q  = state == WAIT && mul_done && cnt >= CW'(DONE_MASK);
    tmo     = state == WAIT && cnt == CW'(TIMEOUT - 1);
    state_n = state == IDLE  ? (acc ? (zero ? HOLD : START) : IDLE) :
              state == START ? WAIT :
              state == WAIT  ? (done_q || tmo ? HOLD : WAIT) :
                               (rsp_ready ? IDLE : HOLD);
  end
  // state, wait counter, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      rsp_result       <= '0;
      rsp_timeout      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= state == WAIT ? cnt + 1'b1 : '0;
      if (acc) begin
        mul_multiplicand <= req_a;
        mul_multiplier   <= req_b;
      end
      if (acc && zero) begin
        rsp_result  <= '0;
        rsp_timeout <= 1'b0;
      end else if (done_q) begin
        rsp_result  <= mul_outbus;
        rsp_timeout <= 1'b0;
      end else if (tmo) begin
        rsp_result  <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mul_dispatch_ctrl.sv
// tb_mul_dispatch_ctrl: scoreboard bench with a queued start/done multiplier model
module tb_mul_dispatch_ctrl;
  localparam int TIMEOUT = 32;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, mul_start, mul_done = 0;
  logic rsp_valid, rsp_ready = 1, rsp_timeout, busy;
  logic [7:0] req_a = 0, req_b = 0, mul_multiplicand, mul_multiplier;
  logic [15:0] mul_outbus = 0, rsp_result;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int done_at = 3, stale_n = 0;
  typedef struct { int c; logic [15:0] p; } fire_t;
  typedef struct { logic [15:0] res; logic to; int lat; int starts; } exp_t;
  fire_t fq[$];
  exp_t sb[$];
  int t_acc = 0, n_start = 0;
  logic prev_valid = 0;

  mul_dispatch_ctrl #(.WIDTH(8), .TIMEOUT(TIMEOUT), .DONE_MASK(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_outbus(mul_outbus), .mul_done(mul_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // multiplier model: done at WAIT counter k is the cycle start+1+k; optional stale dones at counters 0..stale_n-1
  initial forever begin
    @(negedge clk);
    if (fq.size() != 0 && fq[0].c == cyc) begin
      mul_done = 1;
      mul_outbus = fq[0].p;
      void'(fq.pop_front());
    end else mul_done = 0;
    if (mul_start) begin
      for (int i = 0; i < stale_n; i++) fq.push_back('{cyc + 1 + i, 16'hBEEF});
      if (done_at >= 0)
        fq.push_back('{cyc + 1 + done_at, 16'($signed(mul_multiplicand) * $signed(mul_multiplier))});
    end
  end

  // monitor: push expectation on accept, check latency on rsp_valid rise, check result on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start) n_start++;
      if (req_valid && req_ready) begin
        exp_t e;
        logic z;
        z = req_a == 0 || req_b == 0;
        e.res = z || done_at < 0 ? 16'h0 : 16'($signed(req_a) * $signed(req_b));
        e.to = !z && done_at < 0;
        e.lat = z ? 1 : done_at < 0 ? 2 + TIMEOUT : 3 + done_at;
        e.starts = z ? 0 : 1;
        chk("one_outstanding", sb.size(), 0);
        sb.push_back(e);
        t_acc = cyc;
        n_start = 0;
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
        else chk("latency", cyc - t_acc, sb[0].lat);
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        chk("result", rsp_result, sb[0].res);
        chk("timeout_flag", rsp_timeout, sb[0].to);
        chk("start_pulses", n_start, sb[0].starts);
        void'(sb.pop_front());
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int i;
    req_valid = 1;
    req_a = a;
    req_b = b;
    for (i = 0; i < 200 && !req_ready; i++) tick();
    if (i == 200) chk("accept_wait", req_ready, 1);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    chk("drain", sb.size(), 0);
    chk("idle", busy, 0);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    idle_checks("reset");
    chk("reset_result", rsp_result, 0);
    chk("reset_timeout", rsp_timeout, 0);
    chk("reset_opa", mul_multiplicand, 0);
    chk("reset_opb", mul_multiplier, 0);
    // basic 10*5, done at WAIT 3 -> latency 6
    done_at = 3;
    send(8'd10, 8'd5);
    req_valid = 0;
    drain();
    // back-to-back with req_valid held
    send(8'hFD, 8'd7);
    send(8'hF9, 8'hF9);
    req_valid = 0;
    drain();
    // zero bypass
    send(8'hF8, 8'd0);
    req_valid = 0;
    drain();
    send(8'd0, 8'd9);
    req_valid = 0;
    drain();
    // backpressure: rsp_ready low for 5 cycles
    rsp_ready = 0;
    done_at = 2;
    send(8'd4, 8'hFA);
    req_valid = 0;
    for (int i = 0; i < 50 && !rsp_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, 16'hFFE8);
      chk("hold_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("after_accept_busy", busy, 0);
    drain();
    // done exactly at the mask boundary
    done_at = 2;
    send(8'h81, 8'h7F);
    req_valid = 0;
    drain();
    // never done -> timeout
    done_at = -1;
    send(8'd6, 8'd7);
    req_valid = 0;
    drain();
    // only a done at WAIT counter 0 -> ignored, timeout
    stale_n = 1;
    send(8'd2, 8'd3);
    req_valid = 0;
    drain();
    stale_n = 0;
    // reset while waiting, then stale dones inside the mask of a new operation
    send(8'd3, 8'd3);
    req_valid = 0;
    repeat (4) tick();
    chk("in_wait_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    fq.delete();
    idle_checks("midreset");
    done_at = 3;
    stale_n = 2;
    send(8'hFB, 8'hFB);
    req_valid = 0;
    drain();
    stale_n = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1);
  end
endmodule
